// File: rtl/lcd_digit_writer_pkg.sv
// Shared definitions for the LCD character writer: FSM state encoding,
// LCD command/bus-handshake constants and the ASCII characters used by
// the optional leading-zero blanker.
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } lcd_state_t;

    localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;

    localparam logic       LCD_ADDR          = 1'b0;
    localparam logic       LCD_DATA          = 1'b1;

    localparam logic       LCD_BUS_LOCKED    = 1'b1;
    localparam logic       LCD_BUS_UNLOCKED  = 1'b0;

    localparam logic [7:0] CHR_ZERO          = 8'h30;
    localparam logic [7:0] CHR_SPACE         = 8'h20;

endpackage

// File: rtl/lcd_digit_writer_zero_blanker.sv
// Combinational leading-zero blanker on the snapshot path of
// lcd_digit_writer. Leading '0' characters are turned into spaces up to the
// first non-'0' character; the rightmost character is never blanked, so an
// all-zero value still shows a single '0'. Byte 0 is the leftmost character.
module lcd_zero_blanker
    import lcd_pkg::*;
#(
    parameter int NUM_DIGITS = 5
) (
    input  logic [8*NUM_DIGITS-1:0] i_digits,
    output logic [8*NUM_DIGITS-1:0] o_digits
);

    // Walk from the left, blanking zeros while still inside the leading run
    always_comb begin
        logic w_leading;
        o_digits  = i_digits;
        w_leading = 1'b1;
        for (int i = 0; i < NUM_DIGITS - 1; i++) begin
            if (w_leading && (i_digits[i*8 +: 8] == CHR_ZERO)) begin
                o_digits[i*8 +: 8] = CHR_SPACE;
            end else begin
                w_leading = 1'b0;
            end
        end
    end

endmodule

// File: rtl/lcd_digit_writer.sv
// LCD character writer: on a start request snapshots NUM_DIGITS ASCII
// characters and sends one DDRAM set-address command followed by the
// characters over the shared 8-bit LCD bus using a valid/lock handshake.
// A start while busy is remembered (collapsed to one) and served right
// after the current update without returning to idle.
// Optional feature: define LCD_LEADING_ZERO_BLANK_EN to blank leading
// '0' characters at snapshot time.
module lcd_digit_writer
    import lcd_pkg::*;
#(
    parameter int         NUM_DIGITS = 5,
    parameter logic [6:0] START_ADDR = 7'h00
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [8*NUM_DIGITS-1:0] digits,
    input  logic                    busLock,
    output logic                    wrStb,
    output logic                    addrOrData,
    output logic [7:0]              lcdBus,
    output logic                    busy,
    output logic                    done
);

    localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [7:0]       ADDR_CMD = LCD_CMD_SET_DDRAM | {1'b0, START_ADDR};

    lcd_state_t              r_state;
    lcd_state_t              w_next;
    logic [IDX_W-1:0]        r_idx;
    logic [8*NUM_DIGITS-1:0] r_snap;
    logic                    r_pending;
    logic [8*NUM_DIGITS-1:0] w_snap_in;
    logic                    w_writing;
    logic                    w_accept;
    logic                    w_load;
    logic                    w_idx_clr;
    logic                    w_idx_inc;
    logic                    w_pend_set;
    logic                    w_pend_clr;
    logic [7:0]              w_char;

`ifdef LCD_LEADING_ZERO_BLANK_EN
    lcd_zero_blanker #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_blanker (
        .i_digits (digits),
        .o_digits (w_snap_in)
    );
`else
    assign w_snap_in = digits;
`endif

    // A write is in flight in ADDR/DATA; it completes when the bus is free
    assign w_writing  = (r_state == ST_ADDR) || (r_state == ST_DATA);
    assign w_accept   = w_writing && (busLock == LCD_BUS_UNLOCKED);
    assign w_pend_set = start && w_writing;
    assign w_char     = r_snap[r_idx*8 +: 8];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_idx_clr  = 1'b0;
        w_idx_inc  = 1'b0;
        w_pend_clr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (w_accept) begin
                    w_idx_clr = 1'b1;
                    w_next    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_accept) begin
                    if (r_idx == LAST_IDX) begin
                        w_next = ST_DONE;
                    end else begin
                        w_idx_inc = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // A start arriving in DONE itself is served immediately too
                if (r_pending || start) begin
                    w_load     = 1'b1;
                    w_pend_clr = 1'b1;
                    w_next     = ST_ADDR;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Snapshot, character index and pending-request flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_snap    <= '0;
            r_idx     <= '0;
            r_pending <= 1'b0;
        end else begin
            if (w_load) begin
                r_snap <= w_snap_in;
            end
            if (w_idx_clr) begin
                r_idx <= '0;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + 1'b1;
            end
            if (w_pend_clr) begin
                r_pending <= 1'b0;
            end else if (w_pend_set) begin
                r_pending <= 1'b1;
            end
        end
    end

    // Bus outputs decoded purely from registered state, so they change only on the clock edge
    always_comb begin
        wrStb      = w_writing;
        addrOrData = (r_state == ST_DATA) ? LCD_DATA : LCD_ADDR;
        busy       = (r_state != ST_IDLE);
        done       = (r_state == ST_DONE);
    end

    assign lcdBus = (r_state == ST_ADDR) ? ADDR_CMD :
                    (r_state == ST_DATA) ? w_char   : 8'hzz;

endmodule

// File: tb/tb_lcd_digit_writer.sv
// Scoreboard bench for lcd_digit_writer: stimulus pushes the expected bus
// words of each update into a queue, a negedge monitor pops and compares
// every accepted write and every done pulse.
module tb_lcd_digit_writer;

    localparam int         ND = 5;
    localparam logic [6:0] SA = 7'h40;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic            busLock;
    logic [8*ND-1:0] dig_hold = '0;
    logic [8*ND-1:0] rand_dig;
    logic            scramble = 1'b0;
    logic [8*ND-1:0] digits;
    logic            wrStb, addrOrData, busy, done;
    wire  [7:0]      lcdBus;
    int              lock_mode = 0;

    // expected entry: {is_done, addrOrData, byte}
    logic [9:0] exp_q[$];

    int mon_checks = 0, mon_pass = 0;
    int stim_checks = 0, stim_pass = 0;

    assign digits = scramble ? rand_dig : dig_hold;

    always #5 clk = ~clk;

    lcd_digit_writer #(.NUM_DIGITS(ND), .START_ADDR(SA)) dut (
        .clk(clk), .rst(rst), .start(start), .digits(digits), .busLock(busLock),
        .wrStb(wrStb), .addrOrData(addrOrData), .lcdBus(lcdBus), .busy(busy), .done(done)
    );

    function automatic logic [8*ND-1:0] rnd_chars();
        logic [8*ND-1:0] d;
        for (int i = 0; i < ND; i++)
            d[i*8 +: 8] = ($urandom_range(0, 1) == 0) ? 8'h30 : 8'(8'h30 + $urandom_range(0, 9));
        return d;
    endfunction

    function automatic logic [8*ND-1:0] mk(input string s);
        logic [8*ND-1:0] d;
        for (int i = 0; i < ND; i++) d[i*8 +: 8] = s[i];
        return d;
    endfunction

    // What the display should show for a given snapshot
    function automatic logic [8*ND-1:0] shown(input logic [8*ND-1:0] d);
        logic [8*ND-1:0] r;
        r = d;
`ifdef LCD_LEADING_ZERO_BLANK_EN
        for (int i = 0; i < ND - 1; i++) begin
            if (d[i*8 +: 8] != 8'h30) break;
            r[i*8 +: 8] = 8'h20;
        end
`endif
        return r;
    endfunction

    task automatic push_update(input logic [8*ND-1:0] d);
        logic [8*ND-1:0] s;
        s = shown(d);
        exp_q.push_back({1'b0, 1'b0, 8'h80 | {1'b0, SA}});
        for (int i = 0; i < ND; i++) exp_q.push_back({1'b0, 1'b1, s[i*8 +: 8]});
        exp_q.push_back(10'h200);
    endtask

    task automatic chk_s(input string name, input logic [31:0] act, input logic [31:0] req);
        stim_checks++;
        if (act === req) stim_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    task automatic chk_m(input string name, input logic [31:0] act, input logic [31:0] req);
        mon_checks++;
        if (act === req) mon_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int bound);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk_s("done_timeout", 0, 1);
    endtask

    task automatic issue(input logic [8*ND-1:0] d);
        scramble = 1'b0;
        dig_hold = d;
        push_update(d);
        start = 1'b1;
        tick();
        start = 1'b0;
        scramble = 1'b1;
    endtask

    // Background bus-lock pattern and random digit noise
    initial begin
        int cnt;
        cnt = 0;
        busLock = 1'b0;
        rand_dig = '0;
        forever begin
            @(posedge clk);
            #1;
            rand_dig = rnd_chars();
            case (lock_mode)
                1:       busLock = ($urandom_range(0, 2) == 0);
                2:       busLock = (cnt != 3);
                default: busLock = 1'b0;
            endcase
            cnt = (cnt + 1) % 4;
        end
    end

    // Monitor: compare every accepted write and done pulse with the scoreboard
    initial begin
        bit         held;
        logic [8:0] held_w;
        logic [9:0] e;
        held = 1'b0;
        held_w = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                held = 1'b0;
            end else begin
                if (done === 1'b1) begin
                    if (exp_q.size() == 0) chk_m("unexpected_done", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk_m("done_order", {22'd0, e}, 32'h200);
                    end
                end
                if (wrStb === 1'b1) begin
                    if (held) chk_m("word_stable", {23'd0, addrOrData, lcdBus}, {23'd0, held_w});
                    if (busLock === 1'b1) begin
                        held = 1'b1;
                        held_w = {addrOrData, lcdBus};
                    end else begin
                        held = 1'b0;
                        if (exp_q.size() == 0) chk_m("unexpected_write", {23'd0, addrOrData, lcdBus}, 32'h1ff);
                        else begin
                            e = exp_q.pop_front();
                            chk_m("bus_word", {22'd0, 1'b0, addrOrData, lcdBus}, {22'd0, e});
                        end
                    end
                end else if (held) begin
                    chk_m("wrStb_dropped", 0, 1);
                    held = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [8*ND-1:0] d2;
        int got;
        // Reset values
        #2;
        chk_s("rst_wrStb", wrStb, 0);
        chk_s("rst_addrOrData", addrOrData, 0);
        chk_s("rst_busy", busy, 0);
        chk_s("rst_done", done, 0);
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // Directed "12345" with a free bus: latency and timing
        issue(mk("12345"));
        got = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk_s("first_wrStb", wrStb, 1);
                chk_s("first_busy", busy, 1);
                chk_s("first_cmd", lcdBus, 8'hC0);
            end
            if (done === 1'b1) begin
                got = k;
                break;
            end
        end
        chk_s("start_to_done", got, 7);
        tick();
        chk_s("idle_wrStb", wrStb, 0);
        chk_s("idle_busy", busy, 0);

        // Leading-zero cases under a 3-of-4 locked bus and a random lock
        lock_mode = 2;
        issue(mk("00070"));
        wait_done(300);
        tick();
        lock_mode = 1;
        issue(mk("00000"));
        wait_done(300);
        tick();

        // Restart during the third data write: one extra update, no idle gap
        lock_mode = 0;
        issue(mk("98765"));
        repeat (3) tick();
        d2 = mk("40302");
        scramble = 1'b0;
        dig_hold = d2;
        push_update(d2);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(50);
        @(negedge clk);
        chk_s("no_idle_gap_wrStb", wrStb, 1);
        chk_s("no_idle_gap_cmd", {addrOrData, lcdBus}, 9'h0C0);
        scramble = 1'b1;
        wait_done(50);
        tick();
        repeat (6) tick();

        // Reset during DATA index 2
        issue(mk("13579"));
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk_s("midrst_wrStb", wrStb, 0);
        chk_s("midrst_addrOrData", addrOrData, 0);
        chk_s("midrst_busy", busy, 0);
        chk_s("midrst_done", done, 0);
        exp_q.delete();
        tick();
        rst = 1'b1;
        repeat (8) tick();
        lock_mode = 1;
        issue(rnd_chars());
        wait_done(300);
        tick();

        // Randomised updates, some with a mid-update restart
        for (int n = 0; n < 16; n++) begin
            lock_mode = (n % 2) + 1;
            issue(rnd_chars());
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 4)) tick();
                d2 = rnd_chars();
                scramble = 1'b0;
                dig_hold = d2;
                push_update(d2);
                start = 1'b1;
                tick();
                start = 1'b0;
                wait_done(400);
                @(posedge clk);
                #1;
                scramble = 1'b1;
            end
            wait_done(400);
            tick();
        end

        repeat (10) tick();
        chk_s("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", stim_pass + mon_pass, stim_checks + mon_checks);
        $finish;
    end

endmodule
